// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// opcodes, FSM states and datapath select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_EXC
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SL2  = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT = 2'b10;

  function automatic logic is_mem_state(
    input state_t s
  );
    return (s == S_FETCH) ||
           (s == S_MEMRD) ||
           (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory
// handshake timeout, exceptions and retire counter.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state;
  state_t           next;
  logic [CW-1:0]    wait_cnt;
  logic [1:0]       cause_q;
  logic [1:0]       cause_next;
  logic [CNT_W-1:0] ret_q;
  logic             done;
  logic             timeout;
  logic             retire;

  // Memory completes on mem_ready, or at once without handshake.
  assign done = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

  // A stalled memory state gives up after TIMEOUT cycles.
  assign timeout = (TIMEOUT != 0) &&
                   is_mem_state(state) &&
                   !done &&
                   (wait_cnt == LIMIT);

  assign retired = rst ? '0 : ret_q;

  // State, wait counter, exception cause and retire count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= EXC_NONE;
      ret_q    <= '0;
    end else begin
      state    <= next;
      wait_cnt <= (next == state) ?
                  wait_cnt + CW'(1) : '0;
      cause_q  <= cause_next;
      if (retire)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  // Next state, exception cause capture and retire strobe.
  always_comb begin
    next       = state;
    cause_next = cause_q;
    retire     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (done) begin
          next = S_DECODE;
        end else if (timeout) begin
          next       = S_EXC;
          cause_next = EXC_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_RTYPE): next = S_EXEC;
          (opcode == OP_LW),
          (opcode == OP_SW):    next = S_MEMADR;
          (opcode == OP_BEQ):   next = S_BRANCH;
          (opcode == OP_ADDI):  next = S_ADDIEX;
          (opcode == OP_J):     next = S_JUMP;
          default: begin
            next       = S_EXC;
            cause_next = EXC_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        next = (opcode == OP_LW) ?
               S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (done) begin
          next = S_MEMWB;
        end else if (timeout) begin
          next       = S_EXC;
          cause_next = EXC_TIMEOUT;
        end
      end
      S_MEMWR: begin
        if (done) begin
          next   = S_FETCH;
          retire = 1'b1;
        end else if (timeout) begin
          next       = S_EXC;
          cause_next = EXC_TIMEOUT;
        end
      end
      S_EXEC:   next = S_ALUWB;
      S_ADDIEX: next = S_ADDIWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_ADDIWB,
      S_JUMP: begin
        next   = S_FETCH;
        retire = 1'b1;
      end
      S_EXC:   next = S_FETCH;
      default: next = S_FETCH;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    exc_valid     = 1'b0;
    exc_cause     = EXC_NONE;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = done;
          pc_write  = done;
        end
        S_DECODE: begin
          alu_src_b = SRCB_SL2;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCS_JUMP;
        end
        S_EXC: begin
          pc_write  = 1'b1;
          pc_source = PCS_EXC;
          exc_valid = 1'b1;
          exc_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three
// instances (default, TIMEOUT=4, CNT_W=2).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b1;

  logic [2:0] pw, pwc, io, mr, mw, irw;
  logic [2:0] m2r, rd, rw, sa, ev;
  logic [1:0] sb  [3];
  logic [1:0] aop [3];
  logic [1:0] ps  [3];
  logic [1:0] ec  [3];
  logic [31:0] ret [3];
  logic [18:0] vec [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int TO = (g == 1) ? 4 : 16;
    localparam int CW = (g == 2) ? 2 : 32;
    logic [CW-1:0] r;
    multicycle_control #(
      .MEM_WAIT_EN(1),
      .TIMEOUT(TO),
      .CNT_W(CW)
    ) dut (
      .clk(clk),
      .rst(rst),
      .opcode(opcode),
      .mem_ready(mem_ready),
      .pc_write(pw[g]),
      .pc_write_cond(pwc[g]),
      .iord(io[g]),
      .mem_read(mr[g]),
      .mem_write(mw[g]),
      .ir_write(irw[g]),
      .mem_to_reg(m2r[g]),
      .reg_dst(rd[g]),
      .reg_write(rw[g]),
      .alu_src_a(sa[g]),
      .alu_src_b(sb[g]),
      .alu_op(aop[g]),
      .pc_source(ps[g]),
      .exc_valid(ev[g]),
      .exc_cause(ec[g]),
      .retired(r)
    );
    assign ret[g] = 32'(r);
    assign vec[g] = {pw[g], pwc[g], io[g], mr[g],
                     mw[g], irw[g], m2r[g], rd[g],
                     rw[g], sa[g], sb[g], aop[g],
                     ps[g], ev[g], ec[g]};
  end

  function automatic logic [18:0] c(
    input logic pw_, pwc_, io_, mr_, mw_,
    input logic irw_, m2r_, rd_, rw_, sa_,
    input logic [1:0] sb_, aop_, ps_,
    input logic ev_,
    input logic [1:0] ec_
  );
    return {pw_, pwc_, io_, mr_, mw_, irw_, m2r_,
            rd_, rw_, sa_, sb_, aop_, ps_, ev_, ec_};
  endfunction

  localparam logic [18:0] V_ZERO = '0;
  localparam logic [18:0] V_FDONE =
    c(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_FWAIT =
    c(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_DEC =
    c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_MADR =
    c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_MRD =
    c(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_MWB =
    c(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_MWR =
    c(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_EXEC =
    c(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,2'b00);
  localparam logic [18:0] V_AWB =
    c(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_BR =
    c(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,2'b00);
  localparam logic [18:0] V_AIEX =
    c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_AIWB =
    c(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,2'b00);
  localparam logic [18:0] V_JMP =
    c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,2'b00);
  localparam logic [18:0] V_EXC_ILL =
    c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,1,2'b01);
  localparam logic [18:0] V_EXC_TO =
    c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,1,2'b10);

  task automatic chk(
    input string tag,
    input int d,
    input logic [18:0] exp
  );
    n_cmp++;
    assert (vec[d] === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, vec[d], exp);
    end
  endtask

  task automatic chkr(
    input string tag,
    input int d,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (ret[d] === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, ret[d], exp);
    end
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic issue(
    input logic [5:0] op,
    input int n
  );
    opcode = op;
    repeat (n) cyc(1'b1);
  endtask

  initial begin
    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_outs", 0, V_ZERO);
    chkr("rst_ret", 0, 0);
    rst = 1'b0;
    opcode = 6'h23;
    #1;
    chk("post_rst_fetch", 0, V_FDONE);

    // lw, ready always 1
    cyc(1); chk("lw_dec", 0, V_DEC);
    cyc(1); chk("lw_madr", 0, V_MADR);
    cyc(1); chk("lw_mrd", 0, V_MRD);
    cyc(1); chk("lw_mwb", 0, V_MWB);
    chkr("lw_ret_before", 0, 0);
    opcode = 6'h2B;
    cyc(1); chk("sw_fetch", 0, V_FDONE);
    chkr("lw_ret_after", 0, 1);

    // sw with three stall cycles in MEMWR
    cyc(1); chk("sw_dec", 0, V_DEC);
    cyc(1); chk("sw_madr", 0, V_MADR);
    cyc(0); chk("sw_wr0", 0, V_MWR);
    cyc(0); chk("sw_wr1", 0, V_MWR);
    cyc(0); chk("sw_wr2", 0, V_MWR);
    chkr("sw_ret_stall", 0, 1);
    cyc(1); chk("sw_wr3", 0, V_MWR);
    opcode = 6'h3F;
    cyc(1); chk("ill_fetch", 0, V_FDONE);
    chkr("sw_ret_after", 0, 2);

    // illegal opcode
    cyc(1); chk("ill_dec", 0, V_DEC);
    cyc(1); chk("ill_exc", 0, V_EXC_ILL);
    chkr("ill_ret_exc", 0, 2);
    opcode = 6'h08;
    cyc(1); chk("ill_back", 0, V_FDONE);
    chkr("ill_ret_after", 0, 2);

    // addi
    cyc(1); chk("addi_dec", 0, V_DEC);
    cyc(1); chk("addi_ex", 0, V_AIEX);
    cyc(1); chk("addi_wb", 0, V_AIWB);
    cyc(1); chk("addi_fetch", 0, V_FDONE);
    chkr("addi_ret", 0, 3);

    // fetch timeout with TIMEOUT=4
    opcode = 6'h00;
    do_reset();
    mem_ready = 1'b0;
    #1;
    chk("to_f0", 1, V_FWAIT);
    cyc(0); chk("to_f1", 1, V_FWAIT);
    cyc(0); chk("to_f2", 1, V_FWAIT);
    cyc(0); chk("to_f3", 1, V_FWAIT);
    cyc(1); chk("to_exc", 1, V_EXC_TO);
    chk("to16_still_fetch", 0, V_FDONE);
    cyc(0); chk("to_back", 1, V_FWAIT);
    chkr("to_ret", 1, 0);

    // ready on the 4th cycle wins over timeout
    cyc(0); chk("rdy_f1", 1, V_FWAIT);
    cyc(0); chk("rdy_f2", 1, V_FWAIT);
    cyc(1); chk("rdy_f3", 1, V_FDONE);
    cyc(1); chk("rdy_dec", 1, V_DEC);

    // retire wrap with CNT_W=2
    opcode = 6'h00;
    do_reset();
    mem_ready = 1'b1;
    #1;
    chk("w_fetch", 2, V_FDONE);
    cyc(1); chk("w_r_dec", 2, V_DEC);
    cyc(1); chk("w_r_exec", 2, V_EXEC);
    cyc(1); chk("w_r_wb", 2, V_AWB);
    opcode = 6'h04;
    cyc(1); chkr("w_ret1", 2, 1);
    cyc(1); chk("w_b_dec", 2, V_DEC);
    cyc(1); chk("w_b_br", 2, V_BR);
    opcode = 6'h02;
    cyc(1); chkr("w_ret2", 2, 2);
    cyc(1); chk("w_j_dec", 2, V_DEC);
    cyc(1); chk("w_j_jmp", 2, V_JMP);
    cyc(1); chkr("w_ret3", 2, 3);
    issue(6'h00, 4); chkr("w_wrap0", 2, 0);
    issue(6'h04, 3); chkr("w_wrap1", 2, 1);
    issue(6'h02, 3); chkr("w_wrap2", 2, 2);

    // reset in EXEC abandons the instruction
    opcode = 6'h00;
    cyc(1); chk("ra_dec", 2, V_DEC);
    cyc(1); chk("ra_exec", 2, V_EXEC);
    rst = 1'b1;
    #1;
    chk("ra_forced", 2, V_ZERO);
    chkr("ra_forced_ret", 2, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ra_fetch", 2, V_FDONE);
    chkr("ra_ret", 2, 0);
    cyc(1); chk("ra_dec2", 2, V_DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the next-generation multi-cycle MIPS datapath. It replaces the single-cycle combinational control unit.
- Sequences each instruction through FETCH/DECODE/execute/memory/writeback states and drives all datapath mux selects and enables.
- Adds a variable-latency memory handshake with timeout, illegal-opcode and bus-error exceptions, and a retired-instruction counter.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states wait on mem_ready; 0 = memory always completes in one cycle (mem_ready ignored).
- TIMEOUT, 16, max cycles spent in one memory state before bus error; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction register bits [31:26]
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request, held until complete
- mem_write  out  1  memory write request, held until complete
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR to register file
- reg_dst  out  1  0 = rt, 1 = rd
- reg_write  out  1  register file write
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  01 = illegal opcode, 10 = bus timeout; 00 otherwise
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset:
  - rst high at a clock edge sets state to FETCH, retired to 0, and the wait counter to 0.
  - While rst is high, all outputs are forced to 0, overriding the state decode.
  - Reset mid-instruction abandons the instruction and does not retire it.
- State outputs and next state:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write assert only on the completing cycle (mem_ready, or always when MEM_WAIT_EN=0). Goes to DECODE on completion, otherwise stays.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
    - 0x00 -> EXEC, 0x23/0x2B -> MEMADR, 0x04 -> BRANCH, 0x08 -> ADDIEX, 0x02 -> JUMP.
    - Any other opcode -> EXC with cause 01.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD (0x23) or MEMWR (0x2B).
  - MEMRD: mem_read=1, iord=1. Goes to MEMWB on completion, otherwise waits.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Retires, then FETCH.
  - MEMWR: mem_write=1, iord=1. Retires on completion, then FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Retires, then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires, then FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Retires, then FETCH.
  - JUMP: pc_write=1, pc_source=10. Retires, then FETCH.
  - EXC: pc_write=1, pc_source=11, exc_valid=1, exc_cause latched. Goes to FETCH; not retired.
- Unlisted outputs are 0 in every state.
- Wait counter:
  - Counts cycles spent in a memory state (FETCH/MEMRD/MEMWR) without completion; clears on any state change.
  - When TIMEOUT!=0, the counter reaches TIMEOUT-1, and mem_ready=0, the next state is EXC with cause 10.
  - mem_ready=1 on that same cycle wins: normal completion, no exception.
- retired increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- Latencies with mem_ready always 1:
  - R-type 4 cycles; lw 5; sw 4; beq 3; addi 4; j 3; illegal 3.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - state enum;
  - alu_op, alu_src_b, pc_source and exc_cause encodings.
- No sub-module: one registered state/counter process plus one combinational decode process.

Test Plan:
- rst high 2 cycles -> all outputs 0, retired=0; first cycle after release: FETCH, mem_read=1, alu_src_b=01.
- lw (opcode 0x23), mem_ready tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 in cycle 5; retired=1 after.
- sw (0x2B), mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, iord=1 throughout; retired increments once.
- Opcode 0x3F -> DECODE then EXC: exc_valid=1, exc_cause=01, pc_source=11, pc_write=1; retired unchanged; then FETCH.
- TIMEOUT=4, mem_ready stuck 0 in FETCH -> 4 FETCH cycles with ir_write=0, then EXC with cause 10. Separately, mem_ready rising on the 4th cycle -> normal DECODE.
- Issue 3 instructions (R, beq, j) with CNT_W=2, starting retired=3 -> wraps to 0, 1, 2. rst asserted in EXEC -> FETCH next cycle, retired=0.
